// File: rtl/p7_mem_arbiter_pkg.sv
// Shared types and defaults for the p7 memory arbiter: response-source encoding
// and default bus widths.
package p7_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_F    = 2'd1,
    SRC_D    = 2'd2,
    SRC_L    = 2'd3
  } src_t;

endpackage

// File: rtl/p7_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; raises force_f at the limit
// so the arbiter hands the next grant to fetch.
module p7_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req,
  input  logic f_gnt,
  input  logic l_lock,
  output logic force_f
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!f_req || f_gnt)
      cnt <= '0;
    else if (!l_lock && (cnt != 4'(LIMIT)))
      cnt <= cnt + 4'd1;
  end

  assign force_f = (cnt == 4'(LIMIT));

endmodule

// File: rtl/p7_mem_arbiter.sv
// Single-port RAM arbiter for fetch, data and loader requesters.
// Define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation guard.
//
// state    | meaning
// ---------+---------------------------------------------
// SRC_NONE | idle, no read response due
// SRC_F    | fetch read data on rdata this cycle
// SRC_D    | data read data on rdata this cycle
// SRC_L    | loader read data on rdata this cycle
module p7_mem_arbiter
  import p7_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              l_req,
  input  logic              l_lock,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("p7_mem_arbiter: STARVE_LIMIT must be 1..15");
  end

  src_t              resp_q, resp_d;
  src_t              sel;
  logic              force_f;
  logic [ADDR_W-1:0] addr_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  p7_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_gnt   (f_gnt),
    .l_lock  (l_lock),
    .force_f (force_f)
  );
`else
  assign force_f = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= SRC_NONE;
      addr_q <= '0;
    end else begin
      resp_q <= resp_d;
      if (sel != SRC_NONE)
        addr_q <= mem_addr;
    end
  end

  always_comb begin
    sel       = SRC_NONE;
    resp_d    = SRC_NONE;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    l_gnt     = 1'b0;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;

    // l_lock shuts out F and D entirely, including a pending forced fetch
    if (!reset) begin
      if (force_f && f_req && !l_lock)
        sel = SRC_F;
      else if (l_req)
        sel = SRC_L;
      else if (d_req && !l_lock)
        sel = SRC_D;
      else if (f_req && !l_lock)
        sel = SRC_F;
    end

    case (sel)
      SRC_F: begin
        f_gnt    = 1'b1;
        mem_addr = f_addr;
        resp_d   = SRC_F;
      end
      SRC_D: begin
        d_gnt     = 1'b1;
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wdata = d_wdata;
        resp_d    = d_we ? SRC_NONE : SRC_D;
      end
      SRC_L: begin
        l_gnt     = 1'b1;
        mem_addr  = l_addr;
        mem_we    = l_we;
        mem_wdata = l_wdata;
        resp_d    = l_we ? SRC_NONE : SRC_L;
      end
      default: ;
    endcase
  end

  assign f_rvalid = (resp_q == SRC_F);
  assign d_rvalid = (resp_q == SRC_D);
  assign l_rvalid = (resp_q == SRC_L);
  assign busy     = (resp_q != SRC_NONE);
  assign rdata    = mem_rdata;

endmodule

// File: tb/tb_p7_mem_arbiter.sv
// Self-checking bench for p7_mem_arbiter: vector table plus response scoreboard.
module tb_p7_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [2:0] G_NONE = 3'b000, G_F = 3'b001, G_D = 3'b010, G_L = 3'b100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 0, d_req = 0, d_we = 0, l_req = 0, l_lock = 0, l_we = 0;
  logic [AW-1:0] f_addr = 0, d_addr = 0, l_addr = 0;
  logic [DW-1:0] d_wdata = 0, l_wdata = 0;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, l_gnt, l_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, rdata, mem_rdata;
  logic          busy;

  p7_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic f; logic [AW-1:0] fa;
    logic d; logic dwe; logic [AW-1:0] da; logic [DW-1:0] dwd;
    logic l; logic lwe; logic [AW-1:0] la; logic [DW-1:0] lwd;
    logic lock; logic [2:0] exp;
  } vec_t;

  typedef struct { logic [2:0] rv; logic [DW-1:0] data; } resp_t;

  resp_t         q[$];
  logic [DW-1:0] model [0:255];
  logic [AW-1:0] last_addr;
  int            n_tests = 0, n_fail = 0;
  vec_t          vecs [0:17];

  function automatic vec_t mk(logic f, logic [AW-1:0] fa, logic d, logic dwe,
                              logic [AW-1:0] da, logic [DW-1:0] dwd, logic l, logic lwe,
                              logic [AW-1:0] la, logic [DW-1:0] lwd, logic lock,
                              logic [2:0] exp);
    vec_t v;
    v.f = f; v.fa = fa; v.d = d; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.l = l; v.lwe = lwe; v.la = la; v.lwd = lwd; v.lock = lock; v.exp = exp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_resp();
    resp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid{l,d,f}", {29'd0, l_rvalid, d_rvalid, f_rvalid}, {29'd0, e.rv});
      chk("busy", {31'd0, busy}, {31'd0, (e.rv != 3'b000)});
      if (e.rv != 3'b000) chk("rdata", {16'd0, rdata}, {16'd0, e.data});
    end
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic apply(vec_t v);
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    resp_t         r;
    f_req = v.f; f_addr = v.fa;
    d_req = v.d; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    l_req = v.l; l_we = v.lwe; l_addr = v.la; l_wdata = v.lwd; l_lock = v.lock;
    #1;
    check_resp();
    chk("gnt{l,d,f}", {29'd0, l_gnt, d_gnt, f_gnt}, {29'd0, v.exp});
    ea = last_addr; ewe = 1'b0; ewd = '0;
    case (v.exp)
      G_L: begin ea = v.la; ewe = v.lwe; ewd = v.lwd; end
      G_D: begin ea = v.da; ewe = v.dwe; ewd = v.dwd; end
      G_F: ea = v.fa;
      default: ;
    endcase
    chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    chk("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
    if (ewe || v.exp == G_NONE) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, ewd});
    r.rv = 3'b000; r.data = '0;
    if (v.exp != G_NONE) begin
      if (ewe) model[ea] = ewd;
      else begin r.rv = v.exp; r.data = model[ea]; end
      last_addr = ea;
    end
    q.push_back(r);
    @(negedge clk);
  endtask

  function automatic resp_t none_resp();
    resp_t r;
    r.rv = 3'b000; r.data = '0;
    return r;
  endfunction

  initial begin
    last_addr = '0;
    //           f  fa     d  we da     dwd       l  we la     lwd       lk exp
    vecs[0]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h05, 16'hA5A5, 0, G_L);
    vecs[1]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h01, 16'h1111, 0, G_L);
    vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h02, 16'h2222, 0, G_L);
    vecs[3]  = mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_F);
    vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_NONE);
    vecs[5]  = mk(1, 8'h05, 1, 0, 8'h10, 16'h0000, 1, 1, 8'h10, 16'h1234, 0, G_L);
    vecs[6]  = mk(1, 8'h05, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_D);
    vecs[7]  = mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_F);
    vecs[8]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_NONE);
    vecs[9]  = mk(0, 8'h00, 1, 0, 8'h01, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_D);
    vecs[10] = mk(0, 8'h00, 1, 0, 8'h02, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_D);
    vecs[11] = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_NONE);
    vecs[12] = mk(1, 8'h30, 1, 0, 8'h01, 16'h0000, 1, 1, 8'h20, 16'hCAFE, 1, G_L);
    vecs[13] = mk(1, 8'h30, 1, 0, 8'h01, 16'h0000, 1, 0, 8'h20, 16'h0000, 0, G_L);
    vecs[14] = mk(0, 8'h00, 1, 1, 8'h07, 16'hBEEF, 0, 0, 8'h00, 16'h0000, 0, G_D);
    vecs[15] = mk(0, 8'h00, 1, 0, 8'h07, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_D);
    vecs[16] = mk(1, 8'h07, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_F);
    vecs[17] = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, G_NONE);

    // Reset state with requests present
    f_req = 1; d_req = 1;
    #2;
    chk("reset gnt", {29'd0, l_gnt, d_gnt, f_gnt}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("reset rvalid", {29'd0, l_rvalid, d_rvalid, f_rvalid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    q.push_back(none_resp());

    for (int i = 0; i < 18; i++) apply(vecs[i]);

    // Lock holds off F and D for 10 cycles, then D wins on release
    for (int i = 0; i < 10; i++)
      apply(mk(1, 8'h05, 1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0, 1, G_NONE));
    apply(mk(1, 8'h05, 1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_D));
    apply(mk(0, 8'h00, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_NONE));

    // Continuous D against continuous F
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      apply(mk(1, 8'h01, 1, 0, 8'h02, 16'h0, 0, 0, 8'h00, 16'h0, 0, (i == 4) ? G_F : G_D));
`else
      apply(mk(1, 8'h01, 1, 0, 8'h02, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_D));
`endif
    end
    apply(mk(0, 8'h00, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_NONE));

    // Reset in the cycle after a D read grant, D still requesting
    apply(mk(0, 8'h00, 1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_D));
    reset = 1;
    #1;
    chk("mid reset gnt", {29'd0, l_gnt, d_gnt, f_gnt}, 32'd0);
    chk("mid reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid reset mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("mid reset rvalid", {29'd0, l_rvalid, d_rvalid, f_rvalid}, 32'd0);
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    q.delete();
    last_addr = '0;
    @(negedge clk);
    reset = 0;
    q.push_back(none_resp());
    apply(mk(0, 8'h00, 1, 0, 8'h02, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_D));
    apply(mk(0, 8'h00, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_NONE));
    apply(mk(0, 8'h00, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, G_NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
